rv_muldiv_iter: RTL
===================

Name: rv_muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations.
- Companion to the combinational rv32e ALU. It sits beside the ALU in the execute stage, and the core stalls on its handshake.
- Radix-2 shift-add multiply and restoring divide. One result bit is produced per cycle.
- Divide-by-zero and signed overflow are handled on a fast path that skips the iteration.

Parameters:
- XLEN, 32, operand and result width; must be ≥ 4 and even.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit is idle and can accept a request.
- op  input  3  funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- kill  input  1  abort the in-flight operation (pipeline flush).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  result value.
- div_by_zero  output  1  set with the result when a div/rem op had b==0.

Behaviour:
- Reset (async, rst_n low): state=IDLE, out_valid=0, result=0, div_by_zero=0, counter=0. Reset is honoured in any state, including mid-operation; the in-flight request is lost.
- States: IDLE, CALC, FIX, DONE.
- in_ready = (state==IDLE). It is combinational from state only.
- Accept occurs on the edge where in_valid & in_ready. At that edge the unit latches op, |a|, |b| and the sign information for the op:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - Others: unsigned.
- Fast path, decided at accept:
  - Div/rem with b==0 → DONE next cycle.
    - DIV/DIVU: result = all ones.
    - REM/REMU: result = a.
    - div_by_zero = 1.
  - DIV/REM with a==signed MIN and b==all ones → DONE next cycle.
    - DIV: result = MIN.
    - REM: result = 0.
    - div_by_zero = 0.
  - Fast-path latency: out_valid high on cycle 1 after accept.
- Normal path: IDLE→CALC.
  - CALC runs exactly XLEN cycles, counter XLEN-1 down to 0, one bit per cycle, into a 2·XLEN-bit accumulator (product or remainder:quotient).
  - CALC→FIX when the counter reaches 0.
  - FIX, 1 cycle: applies sign correction and selects the output.
    - MUL: low XLEN bits of the product.
    - MULH, MULHSU, MULHU: high XLEN bits of the product.
    - Quotient sign = sign(a) xor sign(b).
    - Remainder sign = sign(a).
  - FIX→DONE.
  - Normal latency: out_valid high on cycle XLEN+2 after accept (34 for XLEN=32).
- DONE:
  - out_valid=1 and result/div_by_zero are held stable until out_ready.
  - On the edge with out_valid & out_ready: → IDLE, out_valid=0.
  - A new request can be accepted no earlier than the following cycle; there is no back-to-back overlap.
- kill:
  - In CALC, FIX or DONE: → IDLE on the next edge, out_valid=0, and no result is delivered.
  - kill has priority over out_ready in DONE.
  - kill in IDLE is ignored. kill together with in_valid in IDLE does NOT accept the request.
- Inputs a, b and op are sampled only at accept; later changes have no effect.
- Arithmetic is exact modulo 2^XLEN. The MULHSU signed×unsigned product uses a 2·XLEN-bit two's-complement correction in FIX.

Test Plan:
- Basic multiply: MUL 7×6 → result=42 at cycle 34.
- Signed high product: MULH 0xFFFFFFFF×0xFFFFFFFF → 0.
- Unsigned high product: MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Mixed-sign high product: MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Signed divide/remainder: DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); unsigned variants DIVU 100/7 → 14, REMU → 2. All at cycle 34.
- Divide-by-zero: DIV 5/0 → 0xFFFFFFFF with div_by_zero=1; REMU 5/0 → 5. Both at cycle 1 after accept.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Both at cycle 1.
- Backpressure: hold out_ready=0 for 10 cycles → result stable and in_ready=0 throughout. kill pulsed at CALC cycle 5 → IDLE next cycle, out_valid never asserted.
- Async reset: drop rst_n mid-CALC → out_valid=0 and in_ready=1 immediately after release. Randomised 10k ops vs reference model for XLEN=32 and XLEN=8.

Source files
------------

// File: rtl/rv_muldiv_iter.sv
// Iterative RISC-V M-extension multiply/divide (radix-2 shift-add, restoring divide).
// Latency: XLEN+2 cycles accept-to-result; div-by-zero and signed overflow take 1 cycle.
// Backpressure: single-entry; result held in DONE until out_ready, in_ready only when idle.
module rv_muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    localparam int W2 = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [W2-1:0]     acc_q;
    logic [XLEN-1:0]   opb_q;
    logic [2:0]        op_q;
    logic              a_neg_q, b_neg_q;

    // request decode, only meaningful on the accept edge
    logic            is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic            fast_dz, fast_ovf, accept;

    always_comb begin
        is_div   = op[2];
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        a_mag    = a_neg ? (~a + XLEN'(1)) : a;
        b_mag    = b_neg ? (~b + XLEN'(1)) : b;
        fast_dz  = is_div && (b == '0);
        fast_ovf = ((op == OP_DIV) || (op == OP_REM)) && (a == SMIN) && (&b);
        accept   = in_valid & in_ready & ~kill;
        fast_res = '0;
        if (fast_dz) begin
            fast_res = op[1] ? a : '1;
        end else if (fast_ovf) begin
            fast_res = op[1] ? '0 : SMIN;
        end
    end

    // one iteration step of each algorithm
    logic [XLEN:0]   mul_sum, div_diff;
    logic [W2-1:0]   mul_next, div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_diff = acc_q[W2-1:XLEN-1] - {1'b0, opb_q};
        div_next = div_diff[XLEN] ? {acc_q[W2-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // sign correction and output selection
    logic [W2-1:0]   prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fix_res;

    always_comb begin
        prod_s = (a_neg_q ^ b_neg_q) ? (~acc_q + W2'(1)) : acc_q;
        quo_s  = (a_neg_q ^ b_neg_q) ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
        rem_s  = a_neg_q ? (~acc_q[W2-1:XLEN] + XLEN'(1)) : acc_q[W2-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[W2-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quo_s;
            default:                      fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (fast_dz || fast_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = kill ? IDLE : DONE;
            end
            DONE: begin
                if (kill || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            op_q        <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op;
                a_neg_q <= a_neg;
                b_neg_q <= b_neg;
                // multiplier and dividend both start in the low half
                acc_q   <= {{XLEN{1'b0}}, a_mag};
                opb_q   <= b_mag;
                cnt_q   <= CNT_W'(XLEN - 1);
                if (fast_dz || fast_ovf) begin
                    result      <= fast_res;
                    div_by_zero <= fast_dz;
                end
            end else if (state_q == CALC) begin
                acc_q <= op_q[2] ? div_next : mul_next;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end else if (state_q == FIX) begin
                result      <= fix_res;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule
